// File: rtl/can_ctrl_fifo.sv
// CAN word-stream bridge: AXI4-Lite register block with an RX FIFO, a held TX word
// and sticky W1C interrupt sources.
module can_ctrl_fifo #(
  parameter int RX_DEPTH                   = 16,
  parameter int C_S_AXI_CONTROL_ADDR_WIDTH = 7,
  parameter int C_S_AXI_CONTROL_DATA_WIDTH = 32
) (
  input  logic                                    ap_clk,
  input  logic                                    ap_rst_n,
  input  logic                                    rx_valid,
  input  logic [31:0]                             rx_data,
  input  logic [28:0]                             rx_id,
  input  logic                                    rx_ide,
  input  logic                                    rx_last,
  output logic                                    tx_valid,
  output logic [31:0]                             tx_data,
  input  logic                                    tx_ready,
  input  logic                                    s_axi_control_AWVALID,
  output logic                                    s_axi_control_AWREADY,
  input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]   s_axi_control_AWADDR,
  input  logic                                    s_axi_control_WVALID,
  output logic                                    s_axi_control_WREADY,
  input  logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]   s_axi_control_WDATA,
  input  logic [C_S_AXI_CONTROL_DATA_WIDTH/8-1:0] s_axi_control_WSTRB,
  output logic                                    s_axi_control_BVALID,
  input  logic                                    s_axi_control_BREADY,
  output logic [1:0]                              s_axi_control_BRESP,
  input  logic                                    s_axi_control_ARVALID,
  output logic                                    s_axi_control_ARREADY,
  input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]   s_axi_control_ARADDR,
  output logic                                    s_axi_control_RVALID,
  input  logic                                    s_axi_control_RREADY,
  output logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]   s_axi_control_RDATA,
  output logic [1:0]                              s_axi_control_RRESP,
  output logic                                    interrupt
);
  localparam int AW = C_S_AXI_CONTROL_ADDR_WIDTH;
  localparam int PW = $clog2(RX_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [AW-1:0] A_CTRL = 'h00;
  localparam logic [AW-1:0] A_STAT = 'h04;
  localparam logic [AW-1:0] A_INT  = 'h08;
  localparam logic [AW-1:0] A_TX   = 'h0C;
  localparam logic [AW-1:0] A_META = 'h10;
  localparam logic [AW-1:0] A_RXD  = 'h14;

  typedef struct packed {
    logic [31:0] data;
    logic [28:0] id;
    logic        ide;
    logic        last;
  } rx_ent_t;

  rx_ent_t       mem [RX_DEPTH];
  rx_ent_t       head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          en, ie_rx, ie_ovf, ie_tx;
  logic [2:0]    int_stat, int_set, int_clr;
  logic          live, bvalid, rvalid;
  logic [31:0]   rdata, rd_mux;
  logic          wr_hs, ar_hs, full, nonempty;
  logic          flush, pop, push_req, push, ovf_set, tx_load, tx_done_set;
  logic          unused_ok;

  assign unused_ok = ^s_axi_control_WSTRB;

  // Readies stay low in reset and for the first cycle after release.
  assign wr_hs = live & s_axi_control_AWVALID & s_axi_control_WVALID & ~bvalid;
  assign ar_hs = s_axi_control_ARVALID & s_axi_control_ARREADY;

  assign s_axi_control_AWREADY = wr_hs;
  assign s_axi_control_WREADY  = wr_hs;
  assign s_axi_control_ARREADY = live & ~rvalid;
  assign s_axi_control_BVALID  = bvalid;
  assign s_axi_control_BRESP   = 2'b00;
  assign s_axi_control_RVALID  = rvalid;
  assign s_axi_control_RDATA   = rdata;
  assign s_axi_control_RRESP   = 2'b00;

  assign head     = mem[rd_ptr];
  assign full     = (count == CW'(RX_DEPTH));
  assign nonempty = (count != '0);

  assign flush       = wr_hs && (s_axi_control_AWADDR == A_CTRL) && s_axi_control_WDATA[1];
  assign pop         = ar_hs && (s_axi_control_ARADDR == A_RXD) && nonempty;
  assign push_req    = rx_valid & en & ~flush;
  assign push        = push_req & (~full | pop);
  assign ovf_set     = push_req & full & ~pop;
  assign tx_load     = wr_hs && (s_axi_control_AWADDR == A_TX) && !tx_valid;
  assign tx_done_set = tx_valid & tx_ready;

  assign int_set = {tx_done_set, ovf_set, push & rx_last};
  assign int_clr = (wr_hs && (s_axi_control_AWADDR == A_INT)) ? s_axi_control_WDATA[2:0] : 3'b000;

  always_comb begin
    rd_mux = '0;
    case (s_axi_control_ARADDR)
      A_CTRL: rd_mux = {27'b0, ie_tx, ie_ovf, ie_rx, 1'b0, en};
      A_STAT: rd_mux = {8'b0, 16'(count), 5'b0, tx_valid, full, nonempty};
      A_INT:  rd_mux = {29'b0, int_stat};
      A_META: if (nonempty) rd_mux = {1'b0, head.ide, head.last, head.id};
      A_RXD:  if (nonempty) rd_mux = head.data;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (push) mem[wr_ptr] <= '{data: rx_data, id: rx_id, ide: rx_ide, last: rx_last};
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      live   <= 1'b0;
      bvalid <= 1'b0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      live <= 1'b1;
      if (wr_hs) bvalid <= 1'b1;
      else if (s_axi_control_BREADY) bvalid <= 1'b0;
      if (ar_hs) begin
        rvalid <= 1'b1;
        rdata  <= rd_mux;
      end else if (s_axi_control_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      en     <= 1'b0;
      ie_rx  <= 1'b0;
      ie_ovf <= 1'b0;
      ie_tx  <= 1'b0;
    end else if (wr_hs && (s_axi_control_AWADDR == A_CTRL)) begin
      en     <= s_axi_control_WDATA[0];
      ie_rx  <= s_axi_control_WDATA[2];
      ie_ovf <= s_axi_control_WDATA[3];
      ie_tx  <= s_axi_control_WDATA[4];
    end
  end

  // Push and pop in the same cycle leave count unchanged; flush overrides both.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      int_stat  <= '0;
      interrupt <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
    end else begin
      int_stat  <= (int_stat & ~int_clr) | int_set;
      interrupt <= |(int_stat & {ie_tx, ie_ovf, ie_rx});
      if (tx_load) begin
        tx_valid <= 1'b1;
        tx_data  <= s_axi_control_WDATA;
      end else if (tx_done_set) begin
        tx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_can_ctrl_fifo.sv
// Scoreboard bench for can_ctrl_fifo: a queue model of the RX FIFO and INT_STAT drives
// expected read data, which is queued at request time and popped on RVALID.
module tb_can_ctrl_fifo;
  localparam int D = 16;
  localparam logic [6:0] A_CTRL = 7'h00, A_STAT = 7'h04, A_INT = 7'h08;
  localparam logic [6:0] A_TX = 7'h0C, A_META = 7'h10, A_RXD = 7'h14;

  typedef struct {
    logic [31:0] data;
    logic [31:0] meta;
  } ent_t;

  logic        ap_clk = 1'b0, ap_rst_n = 1'b0;
  logic        rx_valid = 1'b0, rx_ide = 1'b0, rx_last = 1'b0;
  logic [31:0] rx_data = '0;
  logic [28:0] rx_id = '0;
  logic        tx_valid, tx_ready = 1'b0;
  logic [31:0] tx_data;
  logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready, bvalid, bready = 1'b1;
  logic [6:0]  awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0, rdata;
  logic [3:0]  wstrb = 4'hF;
  logic [1:0]  bresp, rresp;
  logic        arvalid = 1'b0, arready, rvalid, rready = 1'b1, interrupt;

  int          n_tests = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  ent_t        rx_q[$];
  logic        m_en = 1'b0, m_txv = 1'b0;
  logic [2:0]  m_int = '0;
  logic [31:0] dummy;

  always #5 ap_clk = ~ap_clk;

  can_ctrl_fifo #(.RX_DEPTH(D)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_id(rx_id), .rx_ide(rx_ide), .rx_last(rx_last),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .s_axi_control_AWVALID(awvalid), .s_axi_control_AWREADY(awready),
    .s_axi_control_AWADDR(awaddr), .s_axi_control_WVALID(wvalid),
    .s_axi_control_WREADY(wready), .s_axi_control_WDATA(wdata),
    .s_axi_control_WSTRB(wstrb), .s_axi_control_BVALID(bvalid),
    .s_axi_control_BREADY(bready), .s_axi_control_BRESP(bresp),
    .s_axi_control_ARVALID(arvalid), .s_axi_control_ARREADY(arready),
    .s_axi_control_ARADDR(araddr), .s_axi_control_RVALID(rvalid),
    .s_axi_control_RREADY(rready), .s_axi_control_RDATA(rdata),
    .s_axi_control_RRESP(rresp), .interrupt(interrupt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    return {8'h0, 16'(rx_q.size()), 5'h0, m_txv, rx_q.size() == D, rx_q.size() != 0};
  endfunction

  task automatic axi_write(input logic [6:0] a, input logic [31:0] d);
    int n;
    @(negedge ap_clk);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    #1;
    while (!awready && n < 20) begin @(negedge ap_clk); #1; n++; end
    if (!awready) chk("aw_timeout", {31'b0, awready}, 32'd1);
    @(posedge ap_clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(posedge ap_clk); #1; n++; end
    chk("bresp", {bvalid, 29'b0, bresp}, 32'h8000_0000);
    @(posedge ap_clk);
  endtask

  task automatic axi_read(input string tag, input logic [6:0] a, output logic [31:0] d);
    int n;
    @(negedge ap_clk);
    araddr = a; arvalid = 1'b1;
    n = 0;
    #1;
    while (!arready && n < 20) begin @(negedge ap_clk); #1; n++; end
    if (!arready) chk({tag, "_ar_timeout"}, {31'b0, arready}, 32'd1);
    @(posedge ap_clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(posedge ap_clk); #1; n++; end
    if (!rvalid) chk({tag, "_r_timeout"}, {31'b0, rvalid}, 32'd1);
    d = rdata;
    if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    else chk(tag, rdata, exp_q.pop_front());
    @(posedge ap_clk);
  endtask

  task automatic rd_chk(input string tag, input logic [6:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    axi_read(tag, a, dummy);
  endtask

  task automatic rd_rx(input string tag);
    logic [31:0] e;
    e = 32'h0;
    if (rx_q.size() != 0) e = rx_q.pop_front().data;
    rd_chk(tag, A_RXD, e);
  endtask

  task automatic wr_ctrl(input logic [31:0] d);
    axi_write(A_CTRL, d);
    m_en = d[0];
    if (d[1]) rx_q.delete();
  endtask

  task automatic rx_drive(input logic [31:0] d, input logic [28:0] id, input logic ide,
                          input logic last);
    @(negedge ap_clk);
    rx_valid = 1'b1; rx_data = d; rx_id = id; rx_ide = ide; rx_last = last;
    @(negedge ap_clk);
    rx_valid = 1'b0;
  endtask

  task automatic rx_push(input logic [31:0] d, input logic [28:0] id, input logic ide,
                         input logic last);
    if (m_en) begin
      if (rx_q.size() < D) begin
        rx_q.push_back('{data: d, meta: {1'b0, ide, last, id}});
        if (last) m_int[0] = 1'b1;
      end else begin
        m_int[1] = 1'b1;
      end
    end
    rx_drive(d, id, ide, last);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_outs", {26'b0, awready, arready, bvalid, rvalid, tx_valid, interrupt}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    @(negedge ap_clk); ap_rst_n = 1'b1;
    rd_chk("status_rst", A_STAT, exp_status());
    rd_rx("rxd_empty");
    rd_chk("status_after_empty_pop", A_STAT, exp_status());
    rd_chk("unmapped", 7'h18, 32'h0);

    // Basic RX with ie_rx
    wr_ctrl(32'h05);
    rx_push(32'hA1, 29'h1ABCDEF0, 1'b1, 1'b0);
    rx_push(32'hA2, 29'h1ABCDEF0, 1'b1, 1'b0);
    rx_push(32'hA3, 29'h1ABCDEF0, 1'b1, 1'b1);
    chk("irq_lat0", {31'b0, interrupt}, 32'd0);
    @(negedge ap_clk);
    chk("irq_lat1", {31'b0, interrupt}, 32'd1);
    rd_chk("meta", A_META, rx_q[0].meta);
    rd_chk("status3", A_STAT, exp_status());
    for (int i = 0; i < 3; i++) rd_rx("rxd_basic");
    rd_chk("status_drained", A_STAT, exp_status());
    rd_chk("int_avail", A_INT, {29'b0, m_int});
    axi_write(A_INT, 32'h7); m_int = '0;

    // Overflow
    wr_ctrl(32'h03);
    for (int i = 0; i < 17; i++) rx_push(32'h300 + 32'(i), 29'(i), 1'b0, 1'b0);
    rd_chk("status_full", A_STAT, exp_status());
    rd_chk("int_ovf", A_INT, {29'b0, m_int});
    axi_write(A_INT, 32'h2); m_int[1] = 1'b0;
    rd_chk("int_ovf_clr", A_INT, {29'b0, m_int});
    begin
      ent_t e;
      e = rx_q.pop_front();
      rx_q.push_back('{data: 32'h3FF, meta: {3'b000, 29'h55}});
      exp_q.push_back(e.data);
      fork
        axi_read("rxd_pushpop", A_RXD, dummy);
        rx_drive(32'h3FF, 29'h55, 1'b0, 1'b0);
      join
    end
    rd_chk("status_pushpop", A_STAT, exp_status());
    rd_chk("int_pushpop", A_INT, {29'b0, m_int});

    // Drain, then wrap pointers with interleaved pops
    while (rx_q.size() != 0) rd_rx("rxd_drain");
    for (int i = 0; i < 10; i++) rx_push(32'h400 + 32'(i), 29'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) rd_rx("rxd_wrap_a");
    for (int i = 10; i < 20; i++) rx_push(32'h400 + 32'(i), 29'(i), 1'b0, 1'b0);
    rd_chk("status_wrap", A_STAT, exp_status());
    for (int i = 0; i < 15; i++) rd_rx("rxd_wrap_b");
    rx_push(32'h500, 29'h1, 1'b0, 1'b0);
    rx_push(32'h501, 29'h2, 1'b0, 1'b0);
    fork
      axi_write(A_CTRL, 32'h03);
      rx_drive(32'h502, 29'h3, 1'b0, 1'b0);
    join
    rx_q.delete();
    rd_chk("status_flush", A_STAT, exp_status());
    rd_chk("int_flush", A_INT, {29'b0, m_int});
    rd_chk("ctrl_flush_rd0", A_CTRL, 32'h1);

    // TX hold and discard
    wr_ctrl(32'h11);
    axi_write(A_TX, 32'hDEADBEEF); m_txv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      chk("tx_hold_v", {31'b0, tx_valid}, 32'd1);
      chk("tx_hold_d", tx_data, 32'hDEADBEEF);
    end
    axi_write(A_TX, 32'h12345678);
    chk("tx_discard", tx_data, 32'hDEADBEEF);
    rd_chk("status_tx", A_STAT, exp_status());
    @(negedge ap_clk); tx_ready = 1'b1;
    @(negedge ap_clk); tx_ready = 1'b0;
    m_txv = 1'b0; m_int[2] = 1'b1;
    chk("tx_done_v", {31'b0, tx_valid}, 32'd0);
    @(negedge ap_clk);
    chk("irq_tx", {31'b0, interrupt}, 32'd1);
    rd_chk("int_tx", A_INT, {29'b0, m_int});

    // B held, then async reset mid-hold
    @(negedge ap_clk);
    awaddr = A_CTRL; wdata = 32'h15; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge ap_clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      chk("b_hold", {31'b0, bvalid}, 32'd1);
      chk("aw_blocked", {31'b0, awready}, 32'd0);
    end
    #2 ap_rst_n = 1'b0;
    #1;
    chk("rst_mid", {26'b0, awready, arready, bvalid, rvalid, tx_valid, interrupt}, 32'h0);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    rx_q.delete(); m_int = '0; m_txv = 1'b0; m_en = 1'b0;
    @(negedge ap_clk); ap_rst_n = 1'b1;
    rd_chk("ctrl_after_rst", A_CTRL, 32'h0);
    rd_chk("status_after_rst", A_STAT, exp_status());
    rd_chk("int_after_rst", A_INT, {29'b0, m_int});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
